pit_rw_sequencer: RTL and testbench
===================================

PIT_RW_SEQUENCER -- requirements
Module: pit_rw_sequencer

Interface
REQ-001 SHALL have ports (name  direction  width  meaning):
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- cs  in  1  chip select, active-high; all bus cycles ignored when 0.
- rd  in  1  read strobe, one clk wide, sampled with cs.
- wr  in  1  write strobe, one clk wide, sampled with cs.
- a  in  2  address: 0/1/2 = counter 0/1/2, 3 = control word.
- din  in  8  write data.
- cnt_val  in  48  live counts; [16n+15:16n] = counter n.
- dout  out  8  read data, registered.
- dout_valid  out  1  one-cycle pulse; dout valid.
- load_val  out  16  count value for counter load.
- load_stb  out  3  one-hot, one-cycle pulse; bit n loads load_val into counter n.
- cw_stb  out  3  one-hot, one-cycle pulse; counter n reprogrammed.
- cw_mode  out  3  mode field accompanying cw_stb.
- cw_bcd  out  1  BCD bit accompanying cw_stb.
REQ-002 SHALL use one clock; reset SHALL be asynchronous and active-high.

Function
REQ-003 SHALL keep, per counter n, the following state: rw_mode[1:0], wr_ptr, rd_ptr, latched, latch_reg[15:0], hold_reg[7:0].
REQ-004 SHALL decode control word din fields as: [7:6] SC (counter select), [5:4] RW, [3:1] mode, [0] BCD.
REQ-005 Control write, SC=11: SHALL be ignored entirely (no read-back support).
REQ-006 Control write, RW!=00:
- rw_mode[SC] <= RW; wr_ptr, rd_ptr and latched for SC cleared; hold_reg discarded.
- cw_stb[SC] pulses the next cycle, with cw_mode/cw_bcd held valid during the pulse.
REQ-007 Control write, RW=00 (latch command):
- If latched=0: latch_reg <= cnt_val[n]; latched <= 1.
- If latched=1: ignored.
- rw_mode is unchanged; no cw_stb.
REQ-008 Counter write, selected by rw_mode:
- 01: load_val = {8'h00, din}; load_stb pulses.
- 10: load_val = {din, 8'h00}; load_stb pulses.
- 11 with wr_ptr=0: hold_reg <= din; wr_ptr <= 1; no strobe.
- 11 with wr_ptr=1: load_val = {din, hold_reg}; load_stb pulses; wr_ptr <= 0.
- 00 (unprogrammed): ignored.
REQ-009 Counter read: source SHALL be latch_reg if latched=1, else cnt_val[n].
- rw_mode 01 returns LSB; 10 returns MSB.
- rw_mode 11 returns LSB when rd_ptr=0, MSB when rd_ptr=1; rd_ptr then toggles.
- rw_mode 00 returns 8'h00.
REQ-010 latched SHALL clear after the final byte of a sequence is read: the single byte for 01/10, the MSB for 11.
REQ-011 A read at a=3 SHALL return dout=8'h00 and pulse dout_valid.
REQ-012 Latency: dout/dout_valid, load_val/load_stb and cw_* SHALL all be registered, asserted exactly 1 cycle after the strobe cycle, and 1 cycle wide. Outputs SHALL hold their value between pulses.
REQ-013 rd and wr asserted together SHALL perform the write only; no dout_valid is produced.
REQ-014 With cs=0, rd and wr SHALL have no effect on any state or output.
REQ-015 Per-counter state SHALL be independent: access to counter n SHALL NOT alter the pointers or latch of any other counter.
REQ-016 A control write between the LSB and MSB of an RW=11 write SHALL discard the pending LSB and issue no load_stb.

Reset
REQ-017 While rst=1, the block SHALL asynchronously clear:
- all rw_mode to 00;
- all pointers, latched flags, latch_reg and hold_reg to 0;
- dout, load_val and cw_mode to 0;
- dout_valid, load_stb, cw_stb and cw_bcd to 0.
REQ-018 Reset mid-sequence SHALL abandon any pending LSB or latch; the first cycle after release SHALL accept bus cycles.

Verification
REQ-019 Bench SHALL cover these directed scenarios:
- Control write 8'h34, then wr a=0 with 8'hCD, then 8'hAB -> cw_stb=001 with cw_mode=2, cw_bcd=0; then a single load_stb=001 with load_val=16'hABCD after the second byte only.
- Counter 1 RW=01, wr 8'h55 -> load_stb=010 with load_val=16'h0055; RW=10, wr 8'h55 -> load_val=16'h5500.
- Counter 2 RW=11, cnt_val[47:32]=16'h1234, latch command 8'h80; cnt_val then changes to 16'h0FFF; two reads -> dout 8'h34 then 8'h12; third read -> 8'hFF (live value, latch released).
- Second latch command while latched -> first latched value preserved.
- rd and wr asserted together, or cs=0 -> no dout_valid; cs=0 write leaves pointers unchanged.
- rst asserted after the LSB of an RW=11 write, then MSB 8'h01 written after release -> no load_stb (rw_mode reset to 00).

Source files
------------

// File: rtl/pit_rw_sequencer.sv
// Bus-side byte sequencer for a three-counter interval timer: decodes control words,
// assembles 16-bit loads from byte writes, and serializes live or latched counts on reads.
module pit_rw_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        cs,
    input  logic        rd,
    input  logic        wr,
    input  logic [1:0]  a,
    input  logic [7:0]  din,
    input  logic [47:0] cnt_val,
    output logic [7:0]  dout,
    output logic        dout_valid,
    output logic [15:0] load_val,
    output logic [2:0]  load_stb,
    output logic [2:0]  cw_stb,
    output logic [2:0]  cw_mode,
    output logic        cw_bcd
);

    logic [1:0]  rw_mode   [3];
    logic [15:0] latch_reg [3];
    logic [7:0]  hold_reg  [3];
    logic [15:0] cnt_arr   [3];
    logic [2:0]  wr_ptr;
    logic [2:0]  rd_ptr;
    logic [2:0]  latched;

    logic        bus_wr;
    logic        bus_rd;
    logic        ctr_sel;
    logic [1:0]  sc;
    logic [1:0]  rw_f;
    logic [15:0] rd_src;
    logic [7:0]  rd_byte;
    logic        rd_last;

    // A simultaneous rd+wr is treated purely as a write.
    always_comb begin
        bus_wr  = cs & wr;
        bus_rd  = cs & rd & ~wr;
        ctr_sel = (a != 2'd3);
        sc      = din[7:6];
        rw_f    = din[5:4];
        for (int n = 0; n < 3; n++) begin
            cnt_arr[n] = cnt_val[16*n +: 16];
        end
    end

    // Byte selected for a counter read, and whether it ends the read sequence.
    always_comb begin
        rd_src  = '0;
        rd_byte = '0;
        rd_last = 1'b0;
        if (ctr_sel) begin
            rd_src = latched[a] ? latch_reg[a] : cnt_arr[a];
            case (rw_mode[a])
                2'b01: begin
                    rd_byte = rd_src[7:0];
                    rd_last = 1'b1;
                end
                2'b10: begin
                    rd_byte = rd_src[15:8];
                    rd_last = 1'b1;
                end
                2'b11: begin
                    rd_byte = rd_ptr[a] ? rd_src[15:8] : rd_src[7:0];
                    rd_last = rd_ptr[a];
                end
                default: begin
                    rd_byte = 8'h00;
                    rd_last = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int n = 0; n < 3; n++) begin
                rw_mode[n]   <= 2'b00;
                latch_reg[n] <= '0;
                hold_reg[n]  <= '0;
            end
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            latched    <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            load_val   <= '0;
            load_stb   <= '0;
            cw_stb     <= '0;
            cw_mode    <= '0;
            cw_bcd     <= 1'b0;
        end else begin
            dout_valid <= 1'b0;
            load_stb   <= '0;
            cw_stb     <= '0;
            if (bus_wr) begin
                if (!ctr_sel) begin
                    // SC=11 is the read-back command, which this block does not support.
                    if (sc != 2'd3) begin
                        if (rw_f != 2'b00) begin
                            rw_mode[sc]  <= rw_f;
                            wr_ptr[sc]   <= 1'b0;
                            rd_ptr[sc]   <= 1'b0;
                            latched[sc]  <= 1'b0;
                            hold_reg[sc] <= '0;
                            cw_stb       <= 3'b001 << sc;
                            cw_mode      <= din[3:1];
                            cw_bcd       <= din[0];
                        end else if (!latched[sc]) begin
                            latch_reg[sc] <= cnt_arr[sc];
                            latched[sc]   <= 1'b1;
                        end
                    end
                end else begin
                    case (rw_mode[a])
                        2'b01: begin
                            load_val <= {8'h00, din};
                            load_stb <= 3'b001 << a;
                        end
                        2'b10: begin
                            load_val <= {din, 8'h00};
                            load_stb <= 3'b001 << a;
                        end
                        2'b11: begin
                            if (!wr_ptr[a]) begin
                                hold_reg[a] <= din;
                                wr_ptr[a]   <= 1'b1;
                            end else begin
                                load_val  <= {din, hold_reg[a]};
                                load_stb  <= 3'b001 << a;
                                wr_ptr[a] <= 1'b0;
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end else if (bus_rd) begin
                dout_valid <= 1'b1;
                dout       <= rd_byte;
                if (ctr_sel) begin
                    if (rw_mode[a] == 2'b11) begin
                        rd_ptr[a] <= ~rd_ptr[a];
                    end
                    if (latched[a] && rd_last) begin
                        latched[a] <= 1'b0;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_pit_rw_sequencer.sv
// Self-checking bench for pit_rw_sequencer: directed scenarios against fixed values,
// then randomized bus traffic against a byte-queue reference model.
module tb_pit_rw_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        cs;
    logic        rd;
    logic        wr;
    logic [1:0]  a;
    logic [7:0]  din;
    logic [47:0] cnt_val;
    logic [7:0]  dout;
    logic        dout_valid;
    logic [15:0] load_val;
    logic [2:0]  load_stb;
    logic [2:0]  cw_stb;
    logic [2:0]  cw_mode;
    logic        cw_bcd;

    int tests_run    = 0;
    int tests_failed = 0;

    pit_rw_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .cs         (cs),
        .rd         (rd),
        .wr         (wr),
        .a          (a),
        .din        (din),
        .cnt_val    (cnt_val),
        .dout       (dout),
        .dout_valid (dout_valid),
        .load_val   (load_val),
        .load_stb   (load_stb),
        .cw_stb     (cw_stb),
        .cw_mode    (cw_mode),
        .cw_bcd     (cw_bcd)
    );

    always #5 clk = ~clk;

    logic [34:0] obs;
    assign obs = {dout_valid, dout, load_stb, load_val, cw_stb, cw_mode, cw_bcd};

    // Reference model: each counter has an access mode, a read phase, a pending write byte
    // and a list of latched bytes still waiting to be read out.
    logic [1:0]  m_mode [3];
    bit          m_hi   [3];
    bit          m_lat  [3];
    int          m_lcnt [3];
    logic [7:0]  m_lb   [3][2];
    bit          m_pv   [3];
    logic [7:0]  m_pb   [3];
    logic [7:0]  exp_dout;
    logic        exp_dv;
    logic [15:0] exp_lv;
    logic [2:0]  exp_ls;
    logic [2:0]  exp_cs;
    logic [2:0]  exp_cm;
    logic        exp_cb;

    function automatic void model_reset();
        for (int n = 0; n < 3; n++) begin
            m_mode[n] = 2'b00;
            m_hi[n]   = 1'b0;
            m_lat[n]  = 1'b0;
            m_lcnt[n] = 0;
            m_pv[n]   = 1'b0;
            m_pb[n]   = 8'h00;
        end
        exp_dout = 8'h00;
        exp_dv   = 1'b0;
        exp_lv   = 16'h0000;
        exp_ls   = 3'b000;
        exp_cs   = 3'b000;
        exp_cm   = 3'b000;
        exp_cb   = 1'b0;
    endfunction

    function automatic void model_step(input logic c, input logic r, input logic w,
                                       input logic [1:0] aa, input logic [7:0] d,
                                       input logic [47:0] cv);
        int n;
        logic [15:0] cur;
        exp_dv = 1'b0;
        exp_ls = 3'b000;
        exp_cs = 3'b000;
        if (!c || (!r && !w)) return;
        if (w) begin
            if (aa == 2'd3) begin
                if (d[7:6] == 2'd3) return;
                n   = int'(d[7:6]);
                cur = cv[16*n +: 16];
                if (d[5:4] != 2'b00) begin
                    m_mode[n] = d[5:4];
                    m_hi[n]   = 1'b0;
                    m_lat[n]  = 1'b0;
                    m_lcnt[n] = 0;
                    m_pv[n]   = 1'b0;
                    exp_cs    = 3'b001 << n;
                    exp_cm    = d[3:1];
                    exp_cb    = d[0];
                end else if (!m_lat[n]) begin
                    m_lat[n] = 1'b1;
                    case (m_mode[n])
                        2'b01: begin m_lb[n][0] = cur[7:0];  m_lcnt[n] = 1; end
                        2'b10: begin m_lb[n][0] = cur[15:8]; m_lcnt[n] = 1; end
                        2'b11: begin
                            if (m_hi[n]) begin
                                m_lb[n][0] = cur[15:8];
                                m_lcnt[n]  = 1;
                            end else begin
                                m_lb[n][0] = cur[7:0];
                                m_lb[n][1] = cur[15:8];
                                m_lcnt[n]  = 2;
                            end
                        end
                        default: m_lcnt[n] = 0;
                    endcase
                end
            end else begin
                n = int'(aa);
                case (m_mode[n])
                    2'b01: begin exp_lv = {8'h00, d}; exp_ls = 3'b001 << n; end
                    2'b10: begin exp_lv = {d, 8'h00}; exp_ls = 3'b001 << n; end
                    2'b11: begin
                        if (!m_pv[n]) begin
                            m_pv[n] = 1'b1;
                            m_pb[n] = d;
                        end else begin
                            exp_lv  = {d, m_pb[n]};
                            exp_ls  = 3'b001 << n;
                            m_pv[n] = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end else begin
            exp_dv = 1'b1;
            if (aa == 2'd3) begin
                exp_dout = 8'h00;
                return;
            end
            n   = int'(aa);
            cur = cv[16*n +: 16];
            if (m_mode[n] == 2'b00) begin
                exp_dout = 8'h00;
            end else if (m_lat[n]) begin
                exp_dout   = m_lb[n][0];
                m_lb[n][0] = m_lb[n][1];
                m_lcnt[n]  = m_lcnt[n] - 1;
                if (m_lcnt[n] == 0) m_lat[n] = 1'b0;
            end else if (m_mode[n] == 2'b01) begin
                exp_dout = cur[7:0];
            end else if (m_mode[n] == 2'b10) begin
                exp_dout = cur[15:8];
            end else begin
                exp_dout = m_hi[n] ? cur[15:8] : cur[7:0];
            end
            if (m_mode[n] == 2'b11) m_hi[n] = !m_hi[n];
        end
    endfunction

    // One bus cycle: drive at the falling edge, sample 1 time unit after the rising edge.
    task automatic applyStimulus(input logic c, input logic r, input logic w,
                                 input logic [1:0] aa, input logic [7:0] d,
                                 input logic [47:0] cv);
        @(negedge clk);
        cs      = c;
        rd      = r;
        wr      = w;
        a       = aa;
        din     = d;
        cnt_val = cv;
        model_step(c, r, w, aa, d, cv);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cs  = 1'b0;
        rd  = 1'b0;
        wr  = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        #2;
        tests_run++;
        if (obs !== 35'd0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs: got %h expected 0", obs);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        applyStimulus(1'b1, 1'b1, 1'b0, 2'd0, 8'h00, 48'h0000_0000_BEEF);
        tests_run++;
        if (dout_valid !== 1'b1 || dout !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL reset_unprogrammed_read: got v=%b d=%h expected v=1 d=00", dout_valid, dout);
        end
    endtask

    task automatic test_cw_and_load16();
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd3, 8'h34, 48'h0);
        tests_run++;
        if (cw_stb !== 3'b001 || cw_mode !== 3'd2 || cw_bcd !== 1'b0 || load_stb !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL cw_34: got stb=%b mode=%0d bcd=%b ls=%b expected stb=001 mode=2 bcd=0 ls=000", cw_stb, cw_mode, cw_bcd, load_stb);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd0, 8'hCD, 48'h0);
        tests_run++;
        if (load_stb !== 3'b000 || cw_stb !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL load16_lsb_nostb: got ls=%b cw=%b expected 000 000", load_stb, cw_stb);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd0, 8'hAB, 48'h0);
        tests_run++;
        if (load_stb !== 3'b001 || load_val !== 16'hABCD) begin
            tests_failed++;
            $display("[TB] FAIL load16_msb: got ls=%b lv=%h expected 001 ABCD", load_stb, load_val);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 48'h0);
        tests_run++;
        if (load_stb !== 3'b000 || load_val !== 16'hABCD || cw_mode !== 3'd2) begin
            tests_failed++;
            $display("[TB] FAIL load16_hold: got ls=%b lv=%h mode=%0d expected 000 ABCD 2", load_stb, load_val, cw_mode);
        end
    endtask

    task automatic test_rw01_rw10();
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd3, 8'h50, 48'h0);
        tests_run++;
        if (cw_stb !== 3'b010) begin
            tests_failed++;
            $display("[TB] FAIL cw_ctr1: got %b expected 010", cw_stb);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd1, 8'h55, 48'h0);
        tests_run++;
        if (load_stb !== 3'b010 || load_val !== 16'h0055) begin
            tests_failed++;
            $display("[TB] FAIL load_rw01: got ls=%b lv=%h expected 010 0055", load_stb, load_val);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd3, 8'h60, 48'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd1, 8'h55, 48'h0);
        tests_run++;
        if (load_stb !== 3'b010 || load_val !== 16'h5500) begin
            tests_failed++;
            $display("[TB] FAIL load_rw10: got ls=%b lv=%h expected 010 5500", load_stb, load_val);
        end
    endtask

    task automatic test_latch_read();
        logic [7:0] want [4];
        want = '{8'h34, 8'h12, 8'hFF, 8'h0F};
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd3, 8'hB0, {16'h1234, 32'h0});
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd3, 8'h80, {16'h1234, 32'h0});
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 2'd2, 8'h00, {16'h0FFF, 32'h0});
            tests_run++;
            if (dout_valid !== 1'b1 || dout !== want[i]) begin
                tests_failed++;
                $display("[TB] FAIL latch_read_%0d: got v=%b d=%h expected v=1 d=%h", i, dout_valid, dout, want[i]);
            end
        end
    endtask

    task automatic test_double_latch();
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd3, 8'h80, {16'h1234, 32'h0});
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd3, 8'h80, {16'h5678, 32'h0});
        applyStimulus(1'b1, 1'b1, 1'b0, 2'd2, 8'h00, {16'h0FFF, 32'h0});
        tests_run++;
        if (dout !== 8'h34) begin
            tests_failed++;
            $display("[TB] FAIL double_latch_lsb: got %h expected 34", dout);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 2'd2, 8'h00, {16'h0FFF, 32'h0});
        tests_run++;
        if (dout !== 8'h12) begin
            tests_failed++;
            $display("[TB] FAIL double_latch_msb: got %h expected 12", dout);
        end
    endtask

    task automatic test_collision_and_cs();
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd3, 8'hB0, 48'h0);
        applyStimulus(1'b1, 1'b1, 1'b1, 2'd2, 8'h11, 48'h0);
        tests_run++;
        if (dout_valid !== 1'b0 || load_stb !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL rdwr_collision: got v=%b ls=%b expected 0 000", dout_valid, load_stb);
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 2'd2, 8'h99, 48'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 2'd2, 8'h00, 48'h0);
        tests_run++;
        if (dout_valid !== 1'b0 || load_stb !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL cs_low: got v=%b ls=%b expected 0 000", dout_valid, load_stb);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd2, 8'h77, 48'h0);
        tests_run++;
        if (load_stb !== 3'b100 || load_val !== 16'h7711) begin
            tests_failed++;
            $display("[TB] FAIL cs_low_wrptr: got ls=%b lv=%h expected 100 7711", load_stb, load_val);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 2'd2, 8'h00, {16'hABCD, 32'h0});
        tests_run++;
        if (dout !== 8'hCD) begin
            tests_failed++;
            $display("[TB] FAIL cs_low_rdptr: got %h expected CD", dout);
        end
        applyStimulus(1'b1, 1'b1, 1'b0, 2'd3, 8'h00, {16'hABCD, 32'h0});
        tests_run++;
        if (dout_valid !== 1'b1 || dout !== 8'h00) begin
            tests_failed++;
            $display("[TB] FAIL read_ctrl_addr: got v=%b d=%h expected 1 00", dout_valid, dout);
        end
    endtask

    task automatic test_cw_abort();
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd3, 8'h30, 48'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd0, 8'h44, 48'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd3, 8'h37, 48'h0);
        tests_run++;
        if (cw_stb !== 3'b001 || cw_mode !== 3'd3 || cw_bcd !== 1'b1 || load_stb !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL cw_abort_cw: got stb=%b mode=%0d bcd=%b ls=%b expected 001 3 1 000", cw_stb, cw_mode, cw_bcd, load_stb);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd0, 8'h01, 48'h0);
        tests_run++;
        if (load_stb !== 3'b000) begin
            tests_failed++;
            $display("[TB] FAIL cw_abort_nostb: got %b expected 000", load_stb);
        end
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd0, 8'h02, 48'h0);
        tests_run++;
        if (load_stb !== 3'b001 || load_val !== 16'h0201) begin
            tests_failed++;
            $display("[TB] FAIL cw_abort_load: got ls=%b lv=%h expected 001 0201", load_stb, load_val);
        end
    endtask

    task automatic test_reset_mid_sequence();
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd3, 8'h30, 48'h0);
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd0, 8'h22, 48'h0);
        do_reset();
        applyStimulus(1'b1, 1'b0, 1'b1, 2'd0, 8'h01, 48'h0);
        tests_run++;
        if (load_stb !== 3'b000 || load_val !== 16'h0000) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid: got ls=%b lv=%h expected 000 0000", load_stb, load_val);
        end
    endtask

    task automatic test_random();
        logic [34:0] exp_vec;
        logic [47:0] cv;
        logic [7:0]  d;
        logic [1:0]  aa;
        int          kind;
        do_reset();
        cv = {$urandom(), $urandom()};
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) cv = {$urandom(), $urandom()};
            kind = $urandom_range(0, 9);
            aa   = 2'($urandom_range(0, 2));
            d    = 8'($urandom());
            case (kind)
                0:       applyStimulus(1'b1, 1'b0, 1'b0, aa, d, cv);
                1, 2, 3: applyStimulus(1'b1, 1'b0, 1'b1, aa, d, cv);
                4, 5:    applyStimulus(1'b1, 1'b1, 1'b0, 2'($urandom_range(0, 3)), d, cv);
                6, 7:    applyStimulus(1'b1, 1'b0, 1'b1, 2'd3, d, cv);
                8:       applyStimulus(1'b1, 1'b1, 1'b1, 2'($urandom_range(0, 3)), d, cv);
                default: applyStimulus(1'b0, 1'($urandom()), 1'($urandom()), 2'($urandom_range(0, 3)), d, cv);
            endcase
            exp_vec = {exp_dv, exp_dout, exp_ls, exp_lv, exp_cs, exp_cm, exp_cb};
            tests_run++;
            if (obs !== exp_vec) begin
                tests_failed++;
                $display("[TB] FAIL random_%0d: got %h expected %h (v,dout,ls,lv,cw,mode,bcd)", i, obs, exp_vec);
            end
        end
    endtask

    initial begin
        rst     = 1'b1;
        cs      = 1'b0;
        rd      = 1'b0;
        wr      = 1'b0;
        a       = 2'd0;
        din     = 8'h00;
        cnt_val = 48'h0;
        model_reset();
        test_reset();
        test_cw_and_load16();
        test_rw01_rw10();
        test_latch_read();
        test_double_latch();
        test_collision_and_cs();
        test_cw_abort();
        test_reset_mid_sequence();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
